// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: data-cache request/ready handshake, store lane
// steering, load extraction/extension, and a load buffer that survives external freezes.
module mem_stage_lsu #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic [31:0]       store_data,
  input  logic              hold_in,
  output logic              dc_req,
  output logic              dc_we,
  output logic [ADDR_W-1:0] dc_addr,
  output logic [3:0]        dc_wstrb,
  output logic [31:0]       dc_wdata,
  input  logic [31:0]       dc_rdata,
  input  logic              dc_ready,
  output logic [31:0]       DM_data,
  output logic              lsu_stall,
  output logic              misalign,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, HELD} state_t;

  state_t            state_q, state_d;
  logic [31:0]       ld_buf_q, ld_buf_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [1:0]  off;
  logic        is_b, is_h, is_w, is_uns, any_acc, acc, is_load;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext, ld_val;
  logic [3:0]  strb;

  // Access decode: funct3[1:0] selects size, anything not B/H is a word.
  assign off      = alu_out[1:0];
  assign is_b     = (funct3[1:0] == 2'b00);
  assign is_h     = (funct3[1:0] == 2'b01);
  assign is_w     = ~is_b & ~is_h;
  assign is_uns   = funct3[2];
  assign any_acc  = mem_read | mem_write;
  assign misalign = any_acc & ((is_h & off[0]) | (is_w & (off != 2'b00)));
  assign acc      = any_acc & ~misalign;
  assign is_load  = mem_read & ~mem_write;

  // Load lane select and extension.
  assign ld_byte = dc_rdata[8*off +: 8];
  assign ld_half = off[1] ? dc_rdata[31:16] : dc_rdata[15:0];
  assign ld_ext  = is_b ? {{24{~is_uns & ld_byte[7]}}, ld_byte} :
                   is_h ? {{16{~is_uns & ld_half[15]}}, ld_half} : dc_rdata;
  assign ld_val  = is_load ? ld_ext : 32'h0;

  // Store lane steering.
  assign strb     = is_b ? (4'b0001 << off) : is_h ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign dc_addr  = {alu_out[ADDR_W-1:2], 2'b00};
  assign dc_wdata = is_b ? {4{store_data[7:0]}} : is_h ? {2{store_data[15:0]}} : store_data;
  assign dc_we    = dc_req & mem_write;
  assign dc_wstrb = dc_we ? strb : 4'b0000;
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    state_d   = state_q;
    ld_buf_d  = ld_buf_q;
    dc_req    = 1'b0;
    lsu_stall = 1'b0;
    DM_data   = 32'h0;
    case (state_q)
      IDLE: begin
        dc_req = acc;
        if (acc && dc_ready) begin
          ld_buf_d = ld_val;
          DM_data  = ld_val;
          state_d  = hold_in ? HELD : IDLE;
        end else if (acc) begin
          lsu_stall = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        dc_req = 1'b1;
        if (dc_ready) begin
          ld_buf_d = ld_val;
          DM_data  = ld_val;
          state_d  = hold_in ? HELD : IDLE;
        end else begin
          lsu_stall = 1'b1;
        end
      end
      HELD: begin
        // Completed access is frozen: replay the captured value, never re-request.
        DM_data = ld_buf_q;
        if (!hold_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    stall_cnt_d = (lsu_stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ld_buf_q    <= 32'h0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ld_buf_q    <= ld_buf_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed vector table, multi-cycle sequences and
// randomized transactions checked against a transaction-level model.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, hold_in, dc_ready;
  logic [2:0]  funct3;
  logic [31:0] alu_out, store_data, dc_rdata;
  logic        dc_req, dc_we, lsu_stall, misalign;
  logic [31:0] dc_addr, dc_wdata, DM_data, stall_cnt;
  logic [3:0]  dc_wstrb;

  int vectors = 0;
  int miscompares = 0;
  int unsigned model_cnt = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.ADDR_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .alu_out(alu_out), .store_data(store_data), .hold_in(hold_in),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wstrb(dc_wstrb),
    .dc_wdata(dc_wdata), .dc_rdata(dc_rdata), .dc_ready(dc_ready),
    .DM_data(DM_data), .lsu_stall(lsu_stall), .misalign(misalign), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned m_size(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] a);
    return (a % m_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    int unsigned s = m_size(f3);
    int unsigned o = a % 4;
    logic [31:0] v;
    if (s == 1) begin
      v = (rd >> (8 * o)) & 32'hFF;
      if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
    end else if (s == 2) begin
      v = (rd >> (16 * (o / 2))) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    int unsigned s = m_size(f3);
    int unsigned o = a % 4;
    if (s == 1) return 4'(1 << o);
    if (s == 2) return 4'(3 << (o - o % 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    int unsigned s = m_size(f3);
    if (s == 1) return (d & 32'hFF) * 32'h01010101;
    if (s == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  // One instruction: lat miss cycles, completion, then hold cycles in HELD.
  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                         input int lat, input int hold);
    bit access = rd | wr;
    bit mis = access && m_mis(f3, a);
    bit ld = rd && !wr;
    logic [31:0] exp_dm = ld ? m_load(f3, a, rdat) : 32'h0;
    mem_read = rd; mem_write = wr; funct3 = f3; alu_out = a; store_data = sd;
    if (!access || mis) begin
      dc_ready = 1'($urandom); hold_in = 1'b0; dc_rdata = $urandom;
      @(negedge clk);
      chk("noacc_req", 32'(dc_req), 32'(0));
      chk("noacc_stall", 32'(lsu_stall), 32'(0));
      chk("noacc_dm", DM_data, 32'h0);
      chk("noacc_mis", 32'(misalign), 32'(mis));
      @(posedge clk); #1;
      return;
    end
    for (int i = 0; i < lat; i++) begin
      dc_ready = 1'b0; hold_in = 1'($urandom); dc_rdata = $urandom;
      @(negedge clk);
      chk("miss_req", 32'(dc_req), 32'(1));
      chk("miss_stall", 32'(lsu_stall), 32'(1));
      chk("miss_dm", DM_data, 32'h0);
      if (i == 0) chk("miss_addr", dc_addr, a & ~32'h3);
      @(posedge clk); #1;
      model_cnt++;
    end
    dc_ready = 1'b1; dc_rdata = rdat; hold_in = (hold > 0);
    @(negedge clk);
    chk("done_req", 32'(dc_req), 32'(1));
    chk("done_stall", 32'(lsu_stall), 32'(0));
    chk("done_dm", DM_data, exp_dm);
    chk("done_we", 32'(dc_we), 32'(wr));
    chk("done_addr", dc_addr, a & ~32'h3);
    chk("done_strb", 32'(dc_wstrb), wr ? 32'(m_strb(f3, a)) : 32'h0);
    if (wr) chk("done_wdata", dc_wdata, m_wdata(f3, sd));
    @(posedge clk); #1;
    for (int h = 0; h < hold; h++) begin
      hold_in = (h < hold - 1); dc_ready = 1'($urandom); dc_rdata = $urandom;
      @(negedge clk);
      chk("held_req", 32'(dc_req), 32'(0));
      chk("held_stall", 32'(lsu_stall), 32'(0));
      chk("held_dm", DM_data, exp_dm);
      @(posedge clk); #1;
    end
    chk("stall_cnt", stall_cnt, 32'(model_cnt));
  endtask

  // ---------------- directed single-cycle vectors ----------------
  typedef struct {
    logic rd; logic wr; logic [2:0] f3;
    logic [31:0] addr; logic [31:0] sd; logic [31:0] rdata;
    logic req; logic mis; logic [3:0] strb; logic [31:0] wdata; logic [31:0] dm;
  } vec_t;

  vec_t tbl[$];

  initial begin
    tbl.push_back('{1,0,3'd2,32'h100,32'h0,       32'h8899AABB,1,0,4'h0,32'h0,       32'h8899AABB});
    tbl.push_back('{0,1,3'd1,32'h202,32'h0000BEEF,32'h0,       1,0,4'hC,32'hBEEFBEEF,32'h0});
    tbl.push_back('{1,0,3'd2,32'h102,32'h0,       32'h12345678,0,1,4'h0,32'h0,       32'h0});
    tbl.push_back('{1,0,3'd0,32'h103,32'h0,       32'h80112233,1,0,4'h0,32'h0,       32'hFFFFFF80});
    tbl.push_back('{1,0,3'd4,32'h103,32'h0,       32'h80112233,1,0,4'h0,32'h0,       32'h00000080});
    tbl.push_back('{1,0,3'd1,32'h002,32'h0,       32'h80011234,1,0,4'h0,32'h0,       32'hFFFF8001});
    tbl.push_back('{1,0,3'd5,32'h002,32'h0,       32'h80011234,1,0,4'h0,32'h0,       32'h00008001});
    tbl.push_back('{1,0,3'd0,32'h001,32'h0,       32'h80112233,1,0,4'h0,32'h0,       32'h00000022});
    tbl.push_back('{0,1,3'd0,32'h201,32'h12345678,32'h0,       1,0,4'h2,32'h78787878,32'h0});
    tbl.push_back('{0,1,3'd2,32'h300,32'hDEADBEEF,32'h0,       1,0,4'hF,32'hDEADBEEF,32'h0});
    tbl.push_back('{1,0,3'd1,32'h011,32'h0,       32'h0,       0,1,4'h0,32'h0,       32'h0});
    tbl.push_back('{0,1,3'd2,32'h301,32'h11111111,32'h0,       0,1,4'h0,32'h0,       32'h0});
    tbl.push_back('{1,0,3'd7,32'h104,32'h0,       32'hCAFEF00D,1,0,4'h0,32'h0,       32'hCAFEF00D});
    tbl.push_back('{0,0,3'd2,32'h100,32'h0,       32'h5555AAAA,0,0,4'h0,32'h0,       32'h0});
    tbl.push_back('{1,1,3'd0,32'h003,32'h000000A5,32'h77777777,1,0,4'h8,32'hA5A5A5A5,32'h0});
    tbl.push_back('{1,0,3'd5,32'h000,32'h0,       32'h1234CAFE,1,0,4'h0,32'h0,       32'h0000CAFE});
  end

  initial begin
    rst = 1'b1; mem_read = 0; mem_write = 0; funct3 = 0; alu_out = 0; store_data = 0;
    hold_in = 0; dc_ready = 0; dc_rdata = 0;
    #12;
    chk("rst_req", 32'(dc_req), 32'(0));
    chk("rst_stall", 32'(lsu_stall), 32'(0));
    chk("rst_dm", DM_data, 32'h0);
    chk("rst_cnt", stall_cnt, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[k]) begin
      mem_read = tbl[k].rd; mem_write = tbl[k].wr; funct3 = tbl[k].f3;
      alu_out = tbl[k].addr; store_data = tbl[k].sd; dc_rdata = tbl[k].rdata;
      dc_ready = 1'b1; hold_in = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_req", k), 32'(dc_req), 32'(tbl[k].req));
      chk($sformatf("v%0d_mis", k), 32'(misalign), 32'(tbl[k].mis));
      chk($sformatf("v%0d_dm", k), DM_data, tbl[k].dm);
      chk($sformatf("v%0d_stall", k), 32'(lsu_stall), 32'(0));
      if (tbl[k].req) begin
        chk($sformatf("v%0d_addr", k), dc_addr, tbl[k].addr & ~32'h3);
        chk($sformatf("v%0d_we", k), 32'(dc_we), 32'(tbl[k].wr));
        chk($sformatf("v%0d_strb", k), 32'(dc_wstrb), 32'(tbl[k].strb));
        if (tbl[k].wr) chk($sformatf("v%0d_wdata", k), dc_wdata, tbl[k].wdata);
      end
      @(posedge clk); #1;
    end
    chk("tbl_cnt", stall_cnt, 32'h0);

    // Multi-cycle sequences.
    run_txn(1, 0, 3'd0, 32'h103, 32'h0, 32'h80112233, 3, 0);
    chk("lb_miss_cnt", stall_cnt, 32'd3);
    run_txn(1, 0, 3'd4, 32'h103, 32'h0, 32'h80112233, 3, 0);
    run_txn(1, 0, 3'd5, 32'h010, 32'h0, 32'h1234CAFE, 0, 4);
    run_txn(0, 1, 3'd1, 32'h202, 32'h0000BEEF, 32'h0, 2, 2);
    run_txn(1, 0, 3'd2, 32'h100, 32'h0, 32'h8899AABB, 1, 1);

    // Randomized transactions.
    for (int n = 0; n < 150; n++) begin
      int op = $urandom_range(0, 3);
      run_txn(op[0], op[1], 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset while a miss is outstanding.
    mem_read = 1; mem_write = 0; funct3 = 3'd2; alu_out = 32'h40; dc_ready = 0; hold_in = 0;
    @(posedge clk); #1;
    chk("wait_req", 32'(dc_req), 32'(1));
    chk("wait_stall", 32'(lsu_stall), 32'(1));
    #2; rst = 1'b1; mem_read = 0;
    #1;
    chk("arst_req", 32'(dc_req), 32'(0));
    chk("arst_stall", 32'(lsu_stall), 32'(0));
    chk("arst_cnt", stall_cnt, 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    model_cnt = 0;
    chk("post_rst_cnt", stall_cnt, 32'h0);
    run_txn(1, 0, 3'd2, 32'h80, 32'h0, 32'h0BADF00D, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
